// File: rtl/wns_pkg.sv
// -----------------------------------------------------------------------------
// wns_pkg
// Shared types and elaboration helpers for the width_narrow_ser serializer.
//   wns_state_e : FSM state encoding (IDLE, SEND)
//   wns_beats   : narrow beats per wide word (IN_W / OUT_W)
//   wns_cfg_ok  : legal-geometry check (IN_W multiple of OUT_W, >= 2 beats)
// -----------------------------------------------------------------------------
package wns_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } wns_state_e;

  function automatic int wns_beats(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic bit wns_cfg_ok(input int in_w, input int out_w);
    if (out_w <= 0) return 1'b0;
    return ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
  endfunction

endpackage

// File: rtl/width_narrow_ser_if.sv
// -----------------------------------------------------------------------------
// width_narrow_ser_if
// Bundles both handshakes of the serializer.
//   Input side : in_valid, in_ready, in_data[IN_W]
//   Output side: out_valid, out_ready, out_data[OUT_W], out_last, out_idx[IDX_W]
// Modports:
//   slave  - the serializer's view (takes words, produces beats)
//   master - the surrounding logic's view (offers words, consumes beats)
// -----------------------------------------------------------------------------
interface width_narrow_ser_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) ();
  localparam int BEATS = IN_W / OUT_W;
  localparam int IDX_W = $clog2(BEATS);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );
endinterface

// File: rtl/wns_top_beat.sv
// -----------------------------------------------------------------------------
// wns_top_beat
// Combinational priority encoder: returns the index of the highest lane of a
// wide word whose OUT_W bits are not all zero; returns 0 for an all-zero word.
// Ports:
//   lanes_i   [BEATS*OUT_W] : wide word, lane k = lanes_i[k*OUT_W +: OUT_W]
//   top_idx_o [IDX_W]       : index of highest nonzero lane
// Only compiled when WNS_SKIP_ZERO_EN is defined; without it the serializer
// always sends every beat and has no use for this encoder.
// -----------------------------------------------------------------------------
`ifdef WNS_SKIP_ZERO_EN
module wns_top_beat #(
  parameter int OUT_W = 16,
  parameter int BEATS = 2,
  parameter int IDX_W = 1
) (
  input  logic [BEATS*OUT_W-1:0] lanes_i,
  output logic [IDX_W-1:0]       top_idx_o
);

  logic [BEATS-1:0] lane_nz;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign lane_nz[gi] = |lanes_i[gi*OUT_W +: OUT_W];
  end

  // Ascending scan: the last nonzero lane seen wins, i.e. the highest one.
  always_comb begin
    top_idx_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (lane_nz[i]) top_idx_o = IDX_W'(i);
    end
  end

endmodule
`endif

// File: rtl/width_narrow_ser.sv
// -----------------------------------------------------------------------------
// width_narrow_ser
// Wide-to-narrow serializer: takes one IN_W word and emits IN_W/OUT_W beats of
// OUT_W bits, least-significant beat first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : width_narrow_ser_if.slave (input word handshake + output beat
//           handshake with out_last / out_idx)
// Configuration macro:
//   WNS_SKIP_ZERO_EN - when defined, trailing all-zero beats of a word are not
//                      sent (an all-zero word sends a single zero beat).
// in_ready depends combinationally on out_ready so a new word can be taken on
// the same edge that retires the last beat of the previous one.
// -----------------------------------------------------------------------------
module width_narrow_ser
  import wns_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  width_narrow_ser_if.slave bus
);

  localparam int BEATS = wns_beats(IN_W, OUT_W);
  localparam int IDX_W = $clog2(BEATS);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_SEND = SEND;

  if (!wns_cfg_ok(IN_W, OUT_W)) begin : g_cfg_err
    $error("width_narrow_ser: IN_W must be a multiple of OUT_W giving at least 2 beats");
  end

  logic [0:0]       state_q,    state_d;
  logic [IN_W-1:0]  sreg_q,     sreg_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [IDX_W-1:0] cap_last_idx;

  logic sending;
  logic beat_last;
  logic in_fire;
  logic out_fire;

  // Final beat index for the word currently offered on in_data.
`ifdef WNS_SKIP_ZERO_EN
  wns_top_beat #(
    .OUT_W (OUT_W),
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_top_beat (
    .lanes_i   (bus.in_data),
    .top_idx_o (cap_last_idx)
  );
`else
  assign cap_last_idx = IDX_W'(BEATS - 1);
`endif

  assign sending   = (state_q == S_SEND);
  assign beat_last = sending && (idx_q == last_idx_q);
  assign out_fire  = sending && bus.out_ready;
  assign in_fire   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !sending || (beat_last && bus.out_ready);
  assign bus.out_valid = sending;
  assign bus.out_data  = sreg_q[OUT_W-1:0];
  assign bus.out_last  = beat_last;
  assign bus.out_idx   = idx_q;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;

    if (in_fire) begin
      // Covers both the idle load and the back-to-back reload on a last beat.
      state_d    = S_SEND;
      sreg_d     = bus.in_data;
      idx_d      = '0;
      last_idx_d = cap_last_idx;
    end else if (out_fire) begin
      if (beat_last) begin
        // Clear the datapath so nothing of the finished word lingers.
        state_d = S_IDLE;
        sreg_d  = '0;
        idx_d   = '0;
      end else begin
        sreg_d = sreg_q >> OUT_W;
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: doc/width_narrow_ser.md
# width_narrow_ser

Wide-to-narrow word serializer: accepts one IN_W-bit word over a valid/ready handshake and emits it as IN_W/OUT_W narrow beats, least-significant beat first, over a second valid/ready handshake. It is the inverse of the narrow-to-wide zero-extension path. It reconstructs the narrow lanes from a wide bus, so that width-truncation and extension behaviour can be checked end to end in the suite.

## Interface
Parameters:
- IN_W, default 32: input word width. Must be an integer multiple of OUT_W.
- OUT_W, default 16: output beat width.
- BEATS, derived as IN_W/OUT_W: beats per word. Must be at least 2.
- IDX_W, derived as $clog2(BEATS): beat index width.

Ports:
- clk, in, 1: the single clock. All logic is rising-edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- in_valid, in, 1: input word present.
- in_ready, out, 1: serializer can take a word.
- in_data, in, IN_W: input word.
- out_valid, out, 1: beat present.
- out_ready, in, 1: downstream accepts the beat.
- out_data, out, OUT_W: current beat.
- out_last, out, 1: current beat is the final beat of the word.
- out_idx, out, IDX_W: beat number within the word, starting at 0.

## Operation
- State machine with two states, IDLE and SEND. Reset state is IDLE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, load in_data into shift register sreg, set idx=0, compute last_idx, and go to SEND.
- SEND:
  - out_valid=1, out_data=sreg[OUT_W-1:0], out_idx=idx, out_last=(idx==last_idx).
  - On out_valid&&out_ready with out_last=0: shift sreg right by OUT_W with zero fill, and increment idx.
  - On out_valid&&out_ready with out_last=1: return to IDLE. If in_valid is also high in that cycle, load the new word instead and stay in SEND.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This is a combinational path from out_ready to in_ready and is intentional; it makes back-to-back words bubble-free.
- Without the configuration macro, last_idx=BEATS-1.
- No arithmetic is performed. Beats are exact bit slices, beat k = in_data[k*OUT_W +: OUT_W].
- Holding out_ready low holds out_data, out_idx and out_last stable, with out_valid held high.
- in_data is sampled only on the accepting edge. Later changes to it have no effect on the word in flight.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_idx=0, state IDLE, and sreg=0.
- in_ready reads 1 once rst_n is released.
- Latency: beat 0 is valid on the cycle after the input handshake.
- Throughput: one beat per cycle while out_ready=1. A word takes BEATS cycles (fewer with skipping), with no idle cycle between consecutive words.
- Reset mid-word: out_valid drops immediately (asynchronous). The word in flight is discarded, and no residual beat appears after release.
- If out_ready is high while out_valid is low, nothing happens.

## Configuration
- WNS_SKIP_ZERO_EN, when defined:
  - At capture, last_idx is the index of the highest beat that is not all zeros, which strips zero-extension.
  - An all-zero word sends exactly one beat, 0, with out_last=1.
- WNS_SKIP_ZERO_EN, when not defined: all BEATS beats are always sent, and the priority-encoder logic is absent.

## Structure
- Package wns_pkg holds:
  - the state enum typedef (IDLE, SEND);
  - a constant function returning BEATS from IN_W and OUT_W;
  - an elaboration-time check function for the IN_W % OUT_W == 0 and BEATS>=2 rules.
- Sub-module wns_top_beat is the natural split:
  - a combinational priority encoder over BEATS lanes that returns the index of the highest nonzero lane (0 if all lanes are zero);
  - it is instantiated only under WNS_SKIP_ZERO_EN.

## Test plan
1. Single word, IN_W=32, OUT_W=16, in_data=32'h1234_5678, out_ready=1 -> beat 16'h5678 with idx=0 and last=0, then beat 16'h1234 with idx=1 and last=1, then in_ready=1 with out_valid=0.
2. Backpressure: out_ready=0 for 3 cycles during beat 0 of 32'hDEAD_BEEF -> out_data=16'hBEEF and out_valid=1 held stable; 16'hDEAD follows on the cycle after out_ready rises.
3. Back-to-back: in_valid held high with 32'hAAAA_BBBB then 32'hCCCC_DDDD, out_ready=1 -> four consecutive beats BBBB, AAAA, DDDD, CCCC with no bubble; in_ready pulses on the last-beat cycles.
4. Zero-extended input 32'h0000_FFFF -> with WNS_SKIP_ZERO_EN, one beat FFFF with last=1; without it, FFFF then 0000 with last=1.
5. All-zero word 32'h0 with WNS_SKIP_ZERO_EN -> exactly one beat 16'h0000 with out_last=1 and out_idx=0.
6. Reset mid-word: after beat 0 of 32'h1111_2222 is accepted, pulse rst_n low -> out_valid=0 immediately; after release, in_ready=1 and no 16'h1111 beat ever appears.
